// File: rtl/heartbeat_monitor_pkg.sv
// Shared types and constants for the heartbeat monitor: lock FSM encoding, default event code,
// statistics width and the interval-counter width rule.
package heartbeat_monitor_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } hb_state_t;

  localparam logic [7:0] HB_CODE_DEFAULT = 8'h7A;
  localparam int         STAT_W          = 16;

  // One spare bit above P+T+2 so the counter can run past the miss window before saturating.
  function automatic int interval_width(input int p, input int t);
    return $clog2(p + t + 2) + 1;
  endfunction

endpackage

// File: rtl/heartbeat_monitor_sat_counter16.sv
// Statistics counter: synchronous clear has priority over increment, holds at all-ones.
module sat_counter16
  import heartbeat_monitor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [STAT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat receiver: measures intervals between HEARTBEAT_CODE events, tracks lock, counts errors/misses.
// Outputs are registered (one cycle after the event); `HEARTBEAT_FLYWHEEL_EN adds synthetic strobes on misses while locked.
module heartbeat_monitor
  import heartbeat_monitor_pkg::*;
#(
  parameter int         RX_CLK_PER_HEARTBEAT = 1000,
  parameter int         TOLERANCE            = 2,
  parameter int         LOCK_COUNT           = 3,
  parameter int         MISS_LIMIT           = 3,
  parameter logic [7:0] HEARTBEAT_CODE       = HB_CODE_DEFAULT
) (
  input  logic                                                           rxClk,
  input  logic                                                           rxResetN,
  input  logic                                                           rxEventValid,
  input  logic [7:0]                                                     rxEventCode,
  input  logic                                                           clearStats,
  output logic                                                           hbStrobe,
  output logic                                                           hbLocked,
  output logic [interval_width(RX_CLK_PER_HEARTBEAT, TOLERANCE)-1:0]     lastInterval,
  output logic [STAT_W-1:0]                                              errorCount,
  output logic [STAT_W-1:0]                                              missCount
);

  localparam int IW = interval_width(RX_CLK_PER_HEARTBEAT, TOLERANCE);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);

  localparam logic [IW-1:0] LO_LIM   = IW'(RX_CLK_PER_HEARTBEAT - TOLERANCE);
  localparam logic [IW-1:0] HI_LIM   = IW'(RX_CLK_PER_HEARTBEAT + TOLERANCE);
  localparam logic [IW-1:0] WIN_END  = IW'(RX_CLK_PER_HEARTBEAT + TOLERANCE + 1);
  localparam logic [IW-1:0] REANCHOR = IW'(TOLERANCE + 2);

  hb_state_t     state;
  logic [IW-1:0] cnt;
  logic [GW-1:0] good_run;
  logic [MW-1:0] miss_run;

  logic hb;
  logic in_tol;
  logic at_window_end;
  logic miss;
  logic err_inc;
  logic fly;

  assign hb            = rxEventValid && (rxEventCode == HEARTBEAT_CODE);
  assign in_tol        = (cnt >= LO_LIM) && (cnt <= HI_LIM);
  assign at_window_end = (cnt == WIN_END);
  assign miss          = (state == ST_LOCKED) && at_window_end && !hb;
  assign err_inc       = hb && !in_tol && (state != ST_SEARCH);

`ifdef HEARTBEAT_FLYWHEEL_EN
  assign fly = miss;
`else
  assign fly = 1'b0;
`endif

  always_ff @(posedge rxClk) begin
    if (!rxResetN) begin
      state        <= ST_SEARCH;
      cnt          <= '0;
      good_run     <= '0;
      miss_run     <= '0;
      hbStrobe     <= 1'b0;
      hbLocked     <= 1'b0;
      lastInterval <= '0;
    end else begin
      hbStrobe <= hb || fly;

      // After a miss the counter jumps to T+2 so the next nominal heartbeat still reads P.
      if (hb) begin
        cnt <= IW'(1);
      end else if (miss) begin
        cnt <= REANCHOR;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end

      if (hb && (state != ST_SEARCH)) begin
        lastInterval <= cnt;
      end

      case (state)
        ST_SEARCH: begin
          if (hb) begin
            state    <= ST_ACQUIRE;
            good_run <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (hb && in_tol) begin
            if (int'(good_run) + 1 >= LOCK_COUNT) begin
              state    <= ST_LOCKED;
              hbLocked <= 1'b1;
              good_run <= '0;
              miss_run <= '0;
            end else begin
              good_run <= good_run + 1'b1;
            end
          end else if (hb) begin
            good_run <= '0;
          end else if (at_window_end) begin
            state <= ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (hb && in_tol) begin
            miss_run <= '0;
          end else if (hb) begin
            state    <= ST_ACQUIRE;
            hbLocked <= 1'b0;
            good_run <= '0;
          end else if (at_window_end) begin
            if (int'(miss_run) + 1 >= MISS_LIMIT) begin
              state    <= ST_SEARCH;
              hbLocked <= 1'b0;
              miss_run <= '0;
            end else begin
              miss_run <= miss_run + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_SEARCH;
          hbLocked <= 1'b0;
        end
      endcase
    end
  end

  sat_counter16 u_err_cnt (
    .clk   (rxClk),
    .rst_n (rxResetN),
    .inc   (err_inc),
    .clr   (clearStats),
    .count (errorCount)
  );

  sat_counter16 u_miss_cnt (
    .clk   (rxClk),
    .rst_n (rxResetN),
    .inc   (miss),
    .clr   (clearStats),
    .count (missCount)
  );

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Scenario tasks plus a randomized run against a behavioural heartbeat model (P=100, T=2).
module tb_heartbeat_monitor;

  localparam int P      = 100;
  localparam int T      = 2;
  localparam int LOCK_N = 3;
  localparam int MISS_N = 3;
  localparam int IW     = $clog2(P + T + 2) + 1;
  localparam int CMAX   = (1 << IW) - 1;
  localparam int SMAX   = 65535;
`ifdef HEARTBEAT_FLYWHEEL_EN
  localparam int FLY = 1;
`else
  localparam int FLY = 0;
`endif

  logic          rxClk = 1'b0;
  logic          rxResetN;
  logic          rxEventValid;
  logic [7:0]    rxEventCode;
  logic          clearStats;
  logic          hbStrobe;
  logic          hbLocked;
  logic [IW-1:0] lastInterval;
  logic [15:0]   errorCount;
  logic [15:0]   missCount;

  heartbeat_monitor #(
    .RX_CLK_PER_HEARTBEAT (P),
    .TOLERANCE            (T),
    .LOCK_COUNT           (LOCK_N),
    .MISS_LIMIT           (MISS_N),
    .HEARTBEAT_CODE       (8'h7A)
  ) dut (
    .rxClk        (rxClk),
    .rxResetN     (rxResetN),
    .rxEventValid (rxEventValid),
    .rxEventCode  (rxEventCode),
    .clearStats   (clearStats),
    .hbStrobe     (hbStrobe),
    .hbLocked     (hbLocked),
    .lastInterval (lastInterval),
    .errorCount   (errorCount),
    .missCount    (missCount)
  );

  always #5 rxClk = ~rxClk;

  int errors = 0;
  int checks = 0;
  int strobes_seen = 0;

  // Behavioural model: elapsed cycles since the last heartbeat and the lock rules in integer form.
  typedef enum {M_SEARCH, M_ACQUIRE, M_LOCKED} mstate_t;
  mstate_t m_state = M_SEARCH;
  int m_since = 0, m_good = 0, m_miss = 0, m_last = 0, m_err = 0, m_missc = 0;
  bit m_strobe = 0, m_locked = 0;

  task automatic model_step(input bit rst_n, input bit hb, input bit clr);
    bit good, late, miss, err;
    if (!rst_n) begin
      m_state = M_SEARCH; m_since = 0; m_good = 0; m_miss = 0;
      m_last = 0; m_err = 0; m_missc = 0; m_strobe = 0; m_locked = 0;
      return;
    end
    good = hb && (m_since - P <= T) && (P - m_since <= T);
    late = (m_since == P + T + 1);
    miss = (m_state == M_LOCKED) && late && !hb;
    err  = hb && !good && (m_state != M_SEARCH);
    m_strobe = hb || (FLY != 0 && miss);
    if (hb && m_state != M_SEARCH) m_last = m_since;
    if (clr) m_err = 0;
    else if (err && m_err < SMAX) m_err = m_err + 1;
    if (clr) m_missc = 0;
    else if (miss && m_missc < SMAX) m_missc = m_missc + 1;
    case (m_state)
      M_SEARCH: if (hb) begin m_state = M_ACQUIRE; m_good = 0; end
      M_ACQUIRE: begin
        if (good) begin
          m_good = m_good + 1;
          if (m_good == LOCK_N) begin m_state = M_LOCKED; m_miss = 0; end
        end else if (hb) m_good = 0;
        else if (late) m_state = M_SEARCH;
      end
      default: begin
        if (good) m_miss = 0;
        else if (hb) begin m_state = M_ACQUIRE; m_good = 0; end
        else if (late) begin
          m_miss = m_miss + 1;
          if (m_miss == MISS_N) m_state = M_SEARCH;
        end
      end
    endcase
    if (hb) m_since = 1;
    else if (miss) m_since = T + 2;
    else if (m_since < CMAX) m_since = m_since + 1;
    m_locked = (m_state == M_LOCKED);
  endtask

  task automatic cyc(input bit v, input logic [7:0] code, input bit clr);
    rxEventValid = v;
    rxEventCode  = code;
    clearStats   = clr;
    @(posedge rxClk);
    model_step(rxResetN, v && (code == 8'h7A), clr);
    #1;
    rxEventValid = 1'b0;
    clearStats   = 1'b0;
    if (hbStrobe === 1'b1) strobes_seen++;
  endtask

  task automatic hb_evt();
    cyc(1'b1, 8'h7A, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rxResetN = 1'b0;
    cyc(1'b1, 8'h7A, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    rxResetN = 1'b1;
    checks++; if (hbStrobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %0b want 0", hbStrobe); end
    checks++; if (hbLocked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", hbLocked); end
    checks++; if (lastInterval !== '0) begin errors++; $display("FAIL reset_last: got %0d want 0", lastInterval); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", errorCount); end
    checks++; if (missCount !== 16'd0) begin errors++; $display("FAIL reset_miss: got %0d want 0", missCount); end
  endtask

  task automatic test_lock();
    strobes_seen = 0;
    hb_evt();
    checks++; if (hbStrobe !== 1'b1) begin errors++; $display("FAIL lock_strobe0: got %0b want 1", hbStrobe); end
    for (int k = 1; k <= 3; k++) begin
      idle(P - 1);
      hb_evt();
      checks++; if (hbStrobe !== 1'b1) begin errors++; $display("FAIL lock_strobe%0d: got %0b want 1", k, hbStrobe); end
      checks++; if (hbLocked !== (k == 3)) begin errors++; $display("FAIL lock_state%0d: got %0b want %0b", k, hbLocked, k == 3); end
    end
    checks++; if (lastInterval !== IW'(100)) begin errors++; $display("FAIL lock_last: got %0d want 100", lastInterval); end
    checks++; if (strobes_seen != 4) begin errors++; $display("FAIL lock_strobes: got %0d want 4", strobes_seen); end
  endtask

  task automatic test_tolerance();
    idle(1);
    checks++; if (hbStrobe !== 1'b0) begin errors++; $display("FAIL strobe_width: got %0b want 0", hbStrobe); end
    idle(100);
    hb_evt();
    checks++; if (hbLocked !== 1'b1) begin errors++; $display("FAIL tol102_locked: got %0b want 1", hbLocked); end
    checks++; if (lastInterval !== IW'(102)) begin errors++; $display("FAIL tol102_last: got %0d want 102", lastInterval); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL tol102_err: got %0d want 0", errorCount); end
    idle(102);
    hb_evt();
    checks++; if (errorCount !== 16'd1) begin errors++; $display("FAIL tol103_err: got %0d want 1", errorCount); end
    checks++; if (hbLocked !== 1'b0) begin errors++; $display("FAIL tol103_locked: got %0b want 0", hbLocked); end
    checks++; if (lastInterval !== IW'(103)) begin errors++; $display("FAIL tol103_last: got %0d want 103", lastInterval); end
    // From ACQUIRE three good intervals are enough to relock.
    for (int k = 1; k <= 3; k++) begin
      idle(P - 1);
      hb_evt();
    end
    checks++; if (hbLocked !== 1'b1) begin errors++; $display("FAIL relock: got %0b want 1", hbLocked); end
  endtask

  task automatic test_miss();
    strobes_seen = 0;
    cyc(1'b0, 8'h00, 1'b1);
    idle(102);
    checks++; if (missCount !== 16'd1) begin errors++; $display("FAIL miss_count: got %0d want 1", missCount); end
    checks++; if (hbLocked !== 1'b1) begin errors++; $display("FAIL miss_locked: got %0b want 1", hbLocked); end
    checks++; if (hbStrobe !== FLY[0]) begin errors++; $display("FAIL miss_flystrobe: got %0b want %0d", hbStrobe, FLY); end
    idle(96);
    hb_evt();
    checks++; if (lastInterval !== IW'(100)) begin errors++; $display("FAIL miss_last: got %0d want 100", lastInterval); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL miss_err: got %0d want 0", errorCount); end
    checks++; if (hbLocked !== 1'b1) begin errors++; $display("FAIL miss_keep: got %0b want 1", hbLocked); end
    checks++; if (strobes_seen != 1 + FLY) begin errors++; $display("FAIL miss_strobes: got %0d want %0d", strobes_seen, 1 + FLY); end
  endtask

  task automatic test_loss();
    strobes_seen = 0;
    cyc(1'b0, 8'h00, 1'b1);
    idle(102);
    checks++; if (missCount !== 16'd1) begin errors++; $display("FAIL loss_m1: got %0d want 1", missCount); end
    idle(100);
    checks++; if (missCount !== 16'd2) begin errors++; $display("FAIL loss_m2: got %0d want 2", missCount); end
    idle(99);
    checks++; if (hbLocked !== 1'b1) begin errors++; $display("FAIL loss_pre: got %0b want 1", hbLocked); end
    idle(1);
    checks++; if (missCount !== 16'd3) begin errors++; $display("FAIL loss_m3: got %0d want 3", missCount); end
    checks++; if (hbLocked !== 1'b0) begin errors++; $display("FAIL loss_unlock: got %0b want 0", hbLocked); end
    checks++; if (strobes_seen != 3 * FLY) begin errors++; $display("FAIL loss_strobes: got %0d want %0d", strobes_seen, 3 * FLY); end
  endtask

  task automatic test_ignore();
    strobes_seen = 0;
    cyc(1'b0, 8'h7A, 1'b0);
    cyc(1'b1, 8'h70, 1'b0);
    cyc(1'b1, 8'h7B, 1'b0);
    cyc(1'b0, 8'h7A, 1'b0);
    checks++; if (strobes_seen != 0) begin errors++; $display("FAIL ignore_strobes: got %0d want 0", strobes_seen); end
    // A real hb now must still be the first one seen in SEARCH.
    hb_evt();
    checks++; if (lastInterval !== IW'(100)) begin errors++; $display("FAIL ignore_last: got %0d want 100", lastInterval); end
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL ignore_err: got %0d want 0", errorCount); end
    checks++; if (strobes_seen != 1) begin errors++; $display("FAIL ignore_real: got %0d want 1", strobes_seen); end
  endtask

  task automatic test_clear_and_reset();
    idle(9);
    hb_evt();
    checks++; if (errorCount !== 16'd1) begin errors++; $display("FAIL bad10_err: got %0d want 1", errorCount); end
    idle(49);
    cyc(1'b1, 8'h7A, 1'b1);
    checks++; if (errorCount !== 16'd0) begin errors++; $display("FAIL clear_wins: got %0d want 0", errorCount); end
    for (int k = 0; k < 3; k++) begin idle(P - 1); hb_evt(); end
    idle(94);
    hb_evt();
    for (int k = 0; k < 3; k++) begin idle(P - 1); hb_evt(); end
    checks++; if (hbLocked !== 1'b1 || errorCount !== 16'd1) begin
      errors++; $display("FAIL prereset: locked=%0b err=%0d want 1/1", hbLocked, errorCount);
    end
    idle(P - 1);
    rxResetN = 1'b0;
    cyc(1'b1, 8'h7A, 1'b0);
    rxResetN = 1'b1;
    checks++; if ({hbStrobe, hbLocked} !== 2'b00) begin errors++; $display("FAIL midreset_flags: got %0b%0b want 00", hbStrobe, hbLocked); end
    checks++; if (lastInterval !== '0) begin errors++; $display("FAIL midreset_last: got %0d want 0", lastInterval); end
    checks++; if (errorCount !== 16'd0 || missCount !== 16'd0) begin
      errors++; $display("FAIL midreset_stats: err=%0d miss=%0d want 0/0", errorCount, missCount);
    end
    idle(19);
    hb_evt();
    checks++; if (lastInterval !== '0) begin errors++; $display("FAIL postreset_first: got %0d want 0", lastInterval); end
  endtask

  task automatic test_random();
    for (int h = 0; h < 60; h++) begin
      int gap;
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) gap = $urandom_range(P - T, P + T);
      else if (r < 8) gap = $urandom_range(P - 6, P + 6);
      else gap = $urandom_range(150, 330);
      for (int c = 1; c <= gap; c++) begin
        bit v;
        logic [7:0] code;
        bit clr;
        if (c == gap) begin
          v = 1'b1; code = 8'h7A;
        end else begin
          code = 8'($urandom_range(0, 255));
          case ($urandom_range(0, 15))
            0: begin v = 1'b0; code = 8'h7A; end
            1: begin v = 1'b1; if (code == 8'h7A) code = 8'h7B; end
            default: v = 1'b0;
          endcase
        end
        clr = ($urandom_range(0, 299) == 0);
        cyc(v, code, clr);
        checks++; if (hbStrobe !== m_strobe) begin errors++; $display("FAIL rnd_strobe @%0t: got %0b want %0b", $time, hbStrobe, m_strobe); end
        checks++; if (hbLocked !== m_locked) begin errors++; $display("FAIL rnd_locked @%0t: got %0b want %0b", $time, hbLocked, m_locked); end
        checks++; if (lastInterval !== IW'(m_last)) begin errors++; $display("FAIL rnd_last @%0t: got %0d want %0d", $time, lastInterval, m_last); end
        checks++; if (errorCount !== 16'(m_err)) begin errors++; $display("FAIL rnd_err @%0t: got %0d want %0d", $time, errorCount, m_err); end
        checks++; if (missCount !== 16'(m_missc)) begin errors++; $display("FAIL rnd_miss @%0t: got %0d want %0d", $time, missCount, m_missc); end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rxResetN     = 1'b0;
    rxEventValid = 1'b0;
    rxEventCode  = 8'h00;
    clearStats   = 1'b0;
    test_reset();
    test_lock();
    test_tolerance();
    test_miss();
    test_loss();
    test_ignore();
    test_clear_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
